// File: rtl/conv_scan_ctrl.sv
// Scan sequencer for a 3x3 column-accumulating convolution datapath: fetches
// vertical 3-pixel columns from a synchronous-read RAM and hands results downstream.
module conv_scan_ctrl #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic [23:0]       pix,
    output logic [6:0]        count_i,
    output logic [6:0]        count_j,
    input  logic [11:0]       conv_pix,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       out_data,
    output logic [6:0]        out_row,
    output logic [6:0]        out_col
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_F2,
        S_F3,
        S_H0,
        S_H1,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [6:0] SENTINEL = 7'h7F;
    localparam logic [6:0] LAST_COL = 7'(IMG_W - 1);
    localparam logic [6:0] LAST_ROW = 7'(IMG_H - 3);

    state_t      state_reg, state_next;
    logic [6:0]  r_reg, r_next;
    logic [6:0]  c_reg, c_next;
    logic [15:0] stage_reg, stage_next;
    logic [23:0] pix_reg, pix_next;
    logic [6:0]  count_i_reg, count_i_next;
    logic [6:0]  count_j_reg, count_j_next;
    logic [6:0]  out_row_reg, out_row_next;
    logic [6:0]  out_col_reg, out_col_next;

    state_t      adv_state;
    logic [6:0]  adv_r;
    logic [6:0]  adv_c;
    logic [1:0]  row_off;
    logic [6:0]  rd_row;
    logic        rd_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            r_reg       <= '0;
            c_reg       <= '0;
            stage_reg   <= '0;
            pix_reg     <= '0;
            count_i_reg <= SENTINEL;
            count_j_reg <= SENTINEL;
            out_row_reg <= '0;
            out_col_reg <= '0;
        end else begin
            state_reg   <= state_next;
            r_reg       <= r_next;
            c_reg       <= c_next;
            stage_reg   <= stage_next;
            pix_reg     <= pix_next;
            count_i_reg <= count_i_next;
            count_j_reg <= count_j_next;
            out_row_reg <= out_row_next;
            out_col_reg <= out_col_next;
        end
    end

    // Where the scan goes after a column is finished (discarded or accepted).
    always_comb begin
        adv_state = S_F0;
        adv_r     = r_reg;
        adv_c     = c_reg + 7'd1;
        if (c_reg == LAST_COL) begin
            adv_c = 7'd0;
            if (r_reg == LAST_ROW) begin
                adv_state = S_DONE;
            end else begin
                adv_r = r_reg + 7'd1;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        r_next       = r_reg;
        c_next       = c_reg;
        stage_next   = stage_reg;
        pix_next     = pix_reg;
        count_i_next = count_i_reg;
        count_j_next = count_j_reg;
        out_row_next = out_row_reg;
        out_col_next = out_col_reg;
        rd_en        = 1'b0;
        row_off      = 2'd0;
        out_valid    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    r_next     = 7'd0;
                    c_next     = 7'd0;
                    state_next = S_F0;
                end
            end
            S_F0: begin
                rd_en      = 1'b1;
                state_next = S_F1;
            end
            S_F1: begin
                rd_en            = 1'b1;
                row_off          = 2'd1;
                stage_next[7:0]  = mem_rdata;
                state_next       = S_F2;
            end
            S_F2: begin
                rd_en            = 1'b1;
                row_off          = 2'd2;
                stage_next[15:8] = mem_rdata;
                state_next       = S_F3;
            end
            S_F3: begin
                // Column and its indices change on the same edge so the
                // datapath never sees a new index paired with stale pixels.
                pix_next     = {mem_rdata, stage_reg};
                count_i_next = r_reg;
                count_j_next = c_reg;
                state_next   = S_H0;
            end
            S_H0: state_next = S_H1;
            S_H1: begin
                if (c_reg >= 7'd2) begin
                    out_row_next = r_reg;
                    out_col_next = c_reg - 7'd2;
                    state_next   = S_OUT;
                end else begin
                    r_next     = adv_r;
                    c_next     = adv_c;
                    state_next = adv_state;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    r_next     = adv_r;
                    c_next     = adv_c;
                    state_next = adv_state;
                end
            end
            S_DONE: begin
                // Parking on the sentinel guarantees the next frame's (0,0) is a change.
                count_i_next = SENTINEL;
                count_j_next = SENTINEL;
                state_next   = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign rd_row   = r_reg + {5'd0, row_off};
    assign mem_rd   = rd_en;
    assign mem_addr = rd_en ? (ADDR_W'(rd_row) * ADDR_W'(IMG_W) + ADDR_W'(c_reg)) : '0;
    assign busy     = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign done     = (state_reg == S_DONE);
    assign pix      = pix_reg;
    assign count_i  = count_i_reg;
    assign count_j  = count_j_reg;
    assign out_data = conv_pix;
    assign out_row  = out_row_reg;
    assign out_col  = out_col_reg;

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Directed bench for conv_scan_ctrl: a 4x4 instance with RAM[a]=a and a 3x3
// instance with an all-0xFF RAM, each with a behavioural column-accumulating datapath.
module tb_conv_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_a, start_b, ready_a, ready_b;

    logic        busy_a, done_a, mem_rd_a, out_valid_a;
    logic [9:0]  mem_addr_a;
    logic [7:0]  rdata_a;
    logic [23:0] pix_a;
    logic [6:0]  count_i_a, count_j_a, out_row_a, out_col_a;
    logic [11:0] conv_a, out_data_a;

    logic        busy_b, done_b, mem_rd_b, out_valid_b;
    logic [9:0]  mem_addr_b;
    logic [7:0]  rdata_b;
    logic [23:0] pix_b;
    logic [6:0]  count_i_b, count_j_b, out_row_b, out_col_b;
    logic [11:0] conv_b, out_data_b;

    conv_scan_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_rdata(rdata_a), .pix(pix_a),
        .count_i(count_i_a), .count_j(count_j_a), .conv_pix(conv_a),
        .out_valid(out_valid_a), .out_ready(ready_a), .out_data(out_data_a),
        .out_row(out_row_a), .out_col(out_col_a)
    );

    conv_scan_ctrl #(.IMG_W(3), .IMG_H(3), .ADDR_W(10)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_rdata(rdata_b), .pix(pix_b),
        .count_i(count_i_b), .count_j(count_j_b), .conv_pix(conv_b),
        .out_valid(out_valid_b), .out_ready(ready_b), .out_data(out_data_b),
        .out_row(out_row_b), .out_col(out_col_b)
    );

    // Pixel RAMs: one-cycle read latency.
    always @(posedge clk) if (mem_rd_a) rdata_a <= mem_addr_a[7:0];
    always @(posedge clk) if (mem_rd_b) rdata_b <= 8'hFF;

    // Datapath models: register an index change, shift in the column sum, then
    // result = leftmost + rightmost column of the 3-column window on the next edge.
    logic [6:0] pi_a = 7'h7E, pj_a = 7'h7E, pi_b = 7'h7E, pj_b = 7'h7E;
    logic [9:0] s0_a = '0, s1_a = '0, s2_a = '0, s0_b = '0, s1_b = '0, s2_b = '0;
    always @(posedge clk) begin
        if (count_i_a !== pi_a || count_j_a !== pj_a) begin
            pi_a <= count_i_a; pj_a <= count_j_a;
            s2_a <= s1_a; s1_a <= s0_a;
            s0_a <= 10'(pix_a[7:0]) + 10'(pix_a[15:8]) + 10'(pix_a[23:16]);
        end
        conv_a <= 12'(s0_a) + 12'(s2_a);
        if (count_i_b !== pi_b || count_j_b !== pj_b) begin
            pi_b <= count_i_b; pj_b <= count_j_b;
            s2_b <= s1_b; s1_b <= s0_b;
            s0_b <= 10'(pix_b[7:0]) + 10'(pix_b[15:8]) + 10'(pix_b[23:16]);
        end
        conv_b <= 12'(s0_b) + 12'(s2_b);
    end

    logic [25:0] res_a[$];
    logic [25:0] res_b[$];
    logic [9:0]  addr_b[$];
    int done_cnt_a = 0, done_cnt_b = 0;
    int asserts = 0, fails = 0;
    logic [25:0] exp_tab [4];
    logic [9:0]  exp_addr [9];

    always @(posedge clk) begin
        if (rst) begin
            if (out_valid_a && ready_a) res_a.push_back({out_row_a, out_col_a, out_data_a});
            if (out_valid_b && ready_b) res_b.push_back({out_row_b, out_col_b, out_data_b});
            if (mem_rd_b) addr_b.push_back(mem_addr_b);
            if (done_a) done_cnt_a++;
            if (done_b) done_cnt_b++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(output int k);
        k = 0;
        while (!done_a && k < 400) begin
            step();
            k++;
        end
    endtask

    task automatic test_reset();
        asserts++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        asserts++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done_a); end
        asserts++; if (mem_rd_a !== 1'b0) begin fails++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd_a); end
        asserts++; if (mem_addr_a !== 10'd0) begin fails++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr_a); end
        asserts++; if (pix_a !== 24'd0) begin fails++; $display("FAIL reset_pix: got %h want 0", pix_a); end
        asserts++; if (out_valid_a !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid_a); end
        asserts++; if (out_row_a !== 7'd0 || out_col_a !== 7'd0) begin fails++; $display("FAIL reset_out_pos: got %0d,%0d want 0,0", out_row_a, out_col_a); end
        asserts++; if (count_i_a !== 7'h7F || count_j_a !== 7'h7F) begin fails++; $display("FAIL reset_counts: got %h,%h want 7f,7f", count_i_a, count_j_a); end
        asserts++; if (count_j_b !== 7'h7F || busy_b !== 1'b0) begin fails++; $display("FAIL reset_b: got cj=%h busy=%b want 7f,0", count_j_b, busy_b); end
    endtask

    task automatic test_basic();
        int k, base, d0;
        logic [25:0] got;
        base = res_a.size(); d0 = done_cnt_a;
        pulse_start_a();
        asserts++; if (busy_a !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b want 1", busy_a); end
        wait_done_a(k);
        asserts++; if (done_a !== 1'b1) begin fails++; $display("FAIL basic_done_timeout: got %b want 1", done_a); end
        asserts++; if (k !== 52) begin fails++; $display("FAIL basic_latency: got %0d want 52", k); end
        asserts++; if (busy_a !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done: got %b want 0", busy_a); end
        step();
        asserts++; if (res_a.size() - base !== 4) begin fails++; $display("FAIL basic_count: got %0d want 4", res_a.size() - base); end
        for (int i = 0; i < 4; i++) begin
            got = (base + i < res_a.size()) ? res_a[base + i] : 'x;
            asserts++; if (got !== exp_tab[i]) begin fails++; $display("FAIL basic_res%0d: got %h want %h", i, got, exp_tab[i]); end
        end
        asserts++; if (done_cnt_a - d0 !== 1) begin fails++; $display("FAIL basic_done_count: got %0d want 1", done_cnt_a - d0); end
    endtask

    task automatic test_stall();
        int k, base;
        logic [25:0] got;
        base = res_a.size();
        ready_a = 1'b0;
        pulse_start_a();
        k = 0;
        while (!out_valid_a && k < 200) begin step(); k++; end
        asserts++; if (out_valid_a !== 1'b1) begin fails++; $display("FAIL stall_valid_timeout: got %b want 1", out_valid_a); end
        for (int i = 0; i < 5; i++) begin
            asserts++; if (out_valid_a !== 1'b1) begin fails++; $display("FAIL stall_valid%0d: got %b want 1", i, out_valid_a); end
            asserts++; if (out_data_a !== 12'd30) begin fails++; $display("FAIL stall_data%0d: got %0d want 30", i, out_data_a); end
            asserts++; if (mem_rd_a !== 1'b0) begin fails++; $display("FAIL stall_mem_rd%0d: got %b want 0", i, mem_rd_a); end
            step();
        end
        ready_a = 1'b1;
        wait_done_a(k);
        asserts++; if (done_a !== 1'b1) begin fails++; $display("FAIL stall_done_timeout: got %b want 1", done_a); end
        step();
        asserts++; if (res_a.size() - base !== 4) begin fails++; $display("FAIL stall_count: got %0d want 4", res_a.size() - base); end
        for (int i = 0; i < 4; i++) begin
            got = (base + i < res_a.size()) ? res_a[base + i] : 'x;
            asserts++; if (got !== exp_tab[i]) begin fails++; $display("FAIL stall_res%0d: got %h want %h", i, got, exp_tab[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int k, base;
        logic [25:0] got;
        pulse_start_a();
        wait_done_a(k);
        asserts++; if (done_a !== 1'b1) begin fails++; $display("FAIL b2b_first_timeout: got %b want 1", done_a); end
        step();
        asserts++; if (count_j_a !== 7'h7F || count_i_a !== 7'h7F) begin fails++; $display("FAIL b2b_idle_counts: got %h,%h want 7f,7f", count_i_a, count_j_a); end
        base = res_a.size();
        pulse_start_a();
        asserts++; if (count_j_a !== 7'h7F) begin fails++; $display("FAIL b2b_f0_count_j: got %h want 7f", count_j_a); end
        repeat (4) step();
        asserts++; if (count_j_a !== 7'd0 || count_i_a !== 7'd0) begin fails++; $display("FAIL b2b_first_load: got %h,%h want 0,0", count_i_a, count_j_a); end
        wait_done_a(k);
        asserts++; if (k !== 48) begin fails++; $display("FAIL b2b_latency: got %0d want 48", k); end
        step();
        for (int i = 0; i < 4; i++) begin
            got = (base + i < res_a.size()) ? res_a[base + i] : 'x;
            asserts++; if (got !== exp_tab[i]) begin fails++; $display("FAIL b2b_res%0d: got %h want %h", i, got, exp_tab[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int k, base, d0;
        logic [25:0] got;
        pulse_start_a();
        k = 0;
        while (!(out_valid_a && out_row_a == 7'd0 && out_col_a == 7'd1) && k < 200) begin step(); k++; end
        asserts++; if (out_valid_a !== 1'b1) begin fails++; $display("FAIL rmid_reach_out: got %b want 1", out_valid_a); end
        d0 = done_cnt_a;
        rst = 1'b0;
        step();
        asserts++; if (busy_a !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b want 0", busy_a); end
        asserts++; if (out_valid_a !== 1'b0) begin fails++; $display("FAIL rmid_out_valid: got %b want 0", out_valid_a); end
        asserts++; if (count_i_a !== 7'h7F || count_j_a !== 7'h7F) begin fails++; $display("FAIL rmid_counts: got %h,%h want 7f,7f", count_i_a, count_j_a); end
        rst = 1'b1;
        repeat (5) step();
        asserts++; if (done_cnt_a !== d0 || busy_a !== 1'b0) begin fails++; $display("FAIL rmid_no_done: got done=%0d busy=%b want %0d,0", done_cnt_a, busy_a, d0); end
        base = res_a.size();
        pulse_start_a();
        wait_done_a(k);
        step();
        asserts++; if (res_a.size() - base !== 4) begin fails++; $display("FAIL rmid_count: got %0d want 4", res_a.size() - base); end
        for (int i = 0; i < 4; i++) begin
            got = (base + i < res_a.size()) ? res_a[base + i] : 'x;
            asserts++; if (got !== exp_tab[i]) begin fails++; $display("FAIL rmid_res%0d: got %h want %h", i, got, exp_tab[i]); end
        end
    endtask

    task automatic test_start_busy();
        int k, base, d0;
        base = res_a.size(); d0 = done_cnt_a;
        pulse_start_a();
        repeat (10) step();
        start_a = 1'b1;
        repeat (3) step();
        start_a = 1'b0;
        repeat (20) step();
        pulse_start_a();
        wait_done_a(k);
        asserts++; if (done_a !== 1'b1) begin fails++; $display("FAIL sbusy_timeout: got %b want 1", done_a); end
        repeat (20) step();
        asserts++; if (res_a.size() - base !== 4) begin fails++; $display("FAIL sbusy_count: got %0d want 4", res_a.size() - base); end
        asserts++; if (done_cnt_a - d0 !== 1) begin fails++; $display("FAIL sbusy_done_count: got %0d want 1", done_cnt_a - d0); end
        asserts++; if (busy_a !== 1'b0) begin fails++; $display("FAIL sbusy_idle: got %b want 0", busy_a); end
    endtask

    task automatic test_small();
        int k;
        logic [9:0] ga;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        k = 0;
        while (!done_b && k < 200) begin step(); k++; end
        asserts++; if (k !== 19) begin fails++; $display("FAIL small_latency: got %0d want 19", k); end
        step();
        asserts++; if (res_b.size() !== 1) begin fails++; $display("FAIL small_count: got %0d want 1", res_b.size()); end
        asserts++; if (res_b.size() < 1 || res_b[0] !== {7'd0, 7'd0, 12'd1530}) begin fails++; $display("FAIL small_result: got %h want %h", (res_b.size() > 0) ? res_b[0] : 26'h0, {7'd0, 7'd0, 12'd1530}); end
        asserts++; if (addr_b.size() !== 9) begin fails++; $display("FAIL small_addr_count: got %0d want 9", addr_b.size()); end
        for (int i = 0; i < 9; i++) begin
            ga = (i < addr_b.size()) ? addr_b[i] : 'x;
            asserts++; if (ga !== exp_addr[i]) begin fails++; $display("FAIL small_addr%0d: got %0d want %0d", i, ga, exp_addr[i]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_tab[0] = {7'd0, 7'd0, 12'd30};
        exp_tab[1] = {7'd0, 7'd1, 12'd36};
        exp_tab[2] = {7'd1, 7'd0, 12'd54};
        exp_tab[3] = {7'd1, 7'd1, 12'd60};
        exp_addr[0] = 10'd0; exp_addr[1] = 10'd3; exp_addr[2] = 10'd6;
        exp_addr[3] = 10'd1; exp_addr[4] = 10'd4; exp_addr[5] = 10'd7;
        exp_addr[6] = 10'd2; exp_addr[7] = 10'd5; exp_addr[8] = 10'd8;
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        step();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_start_busy();
        test_small();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/conv_scan_ctrl.md
Name: conv_scan_ctrl

Overview:
- Sequencer for the 3x3 column-accumulating convolution datapath.
- Walks a grayscale image stored in a synchronous-read pixel RAM. For each output row it fetches a vertical 3-pixel column per image column and packs it onto the datapath's 24-bit pix bus.
- Drives the datapath's count_i/count_j strobes. Discards the two warm-up columns per row, then hands each valid 12-bit result downstream with valid/ready.

Parameters:
- IMG_W, 28, image width in pixels (3..126).
- IMG_H, 28, image height in pixels (3..126).
- ADDR_W, 10, pixel RAM address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  begin a frame scan; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last result is accepted.
- mem_addr  out  ADDR_W  pixel RAM read address; rdata is valid the following cycle.
- mem_rd  out  1  read enable.
- mem_rdata  in  8  pixel RAM read data.
- pix  out  24  column to datapath: [7:0]=row r, [15:8]=row r+1, [23:16]=row r+2.
- count_i  out  7  output-row index to datapath.
- count_j  out  7  image-column index to datapath.
- conv_pix  in  12  datapath result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  12  equals conv_pix (combinational pass).
- out_row  out  7  result row (0..IMG_H-3).
- out_col  out  7  result column (0..IMG_W-3).

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; busy=0, done=0, mem_rd=0, mem_addr=0, pix=0, out_valid=0, out_row=0, out_col=0; count_i=count_j=7'h7F (idle sentinel). Mid-frame reset aborts immediately; no done pulse.
- Scan state: r in 0..IMG_H-3, c in 0..IMG_W-1. Pixel address = row*IMG_W + col, computed at ADDR_W width.
- IDLE: start=1 -> r=0, c=0, busy=1, go to F0. start in any other state is ignored.
- F0: mem_rd=1, addr(r,c).
- F1: mem_rd=1, addr(r+1,c); capture mem_rdata into stage[7:0].
- F2: mem_rd=1, addr(r+2,c); capture into stage[15:8].
- F3: mem_rd=0; capture into stage[23:16]. On the exit edge load pix<={rdata,stage[15:0]}, count_i<=r, count_j<=c in the same edge.
- H0, H1: hold pix/count stable. The datapath registers the index change at the end of H0 and updates its result at the end of H1.
- After H1:
  - c>=2 -> OUT, with out_row=r, out_col=c-2 loaded on entry.
  - c<2 -> advance.
- OUT: out_valid=1; out_data=conv_pix. Stay while out_ready=0; pix/count are not touched, so the result holds. On out_ready=1, advance. out_valid is low in every other state.
- Advance:
  - c<IMG_W-1 -> c+1, F0.
  - Else if r<IMG_H-3 -> c=0, r+1, F0.
  - Else -> DONE.
- DONE: done=1 for one cycle, busy=0, count_i/count_j<=7'h7F, then IDLE.
- Sentinel rule: every load of count_i/count_j differs from the previous value. This covers the first column (0,0) after reset or after a prior frame, and the row wrap (i changes). The datapath therefore never misses a column.
- Warm-up: the first two columns of every row carry stale accumulator contents from the previous row; they are never emitted.
- Throughput: 6 cycles per column, plus 1+stall cycles per emitted column. Frame = IMG_W*(IMG_H-2)*6 + (IMG_W-2)*(IMG_H-2) cycles with out_ready tied high.

Test Plan:
- IMG_W=4, IMG_H=4, RAM[a]=a, out_ready=1, pulse start -> out (row,col,data) sequence (0,0,30),(0,1,36),(1,0,54),(1,1,60). done pulses exactly once, 52 cycles after start sampled.
- Same setup, out_ready held low for 5 cycles on the first result -> out_valid stays high; out_data=30 is stable throughout; no mem_rd during the stall; the remaining sequence is unchanged.
- Back-to-back frames: start on the cycle after done -> second frame results identical to the first. count_j shows 7'h7F in IDLE, then 0 at the first load.
- rst=0 asserted while in OUT of result (0,1) -> next cycle: IDLE, busy=0, out_valid=0, counts=7'h7F, no done. A restart produces the full correct sequence.
- start pulsed while busy -> ignored; result count stays 4 and done pulses once.
- IMG_W=3, IMG_H=3, RAM all 8'hFF -> single result (0,0), data=12'd1530 (255*6); mem_addr visits 0,3,6,1,4,7,2,5,8.
